// File: rtl/msg_block_cyclic_shifter.sv
// Per-row cyclic rotator for LDPC message columns feeding the parity accumulator.
// Optional macro LDPC_SHIFT_PIPE_EN adds a second output register stage (latency 2).
module msg_block_cyclic_shifter #(
  parameter int unsigned MAX_ZC              = 384,
  parameter int unsigned MUL_SH_BLOCKS_COUNT = 46,
  parameter int unsigned SHIFT_W             = 9
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [SHIFT_W-1:0]                     zc,
  input  logic [4:0]                             max_col_count,
  input  logic                                   msg_valid,
  output logic                                   msg_ready,
  input  logic [MAX_ZC-1:0]                      msg_block,
  input  logic [MUL_SH_BLOCKS_COUNT*SHIFT_W-1:0] shift_val,
  input  logic [MUL_SH_BLOCKS_COUNT-1:0]         row_mask,
  output logic [MUL_SH_BLOCKS_COUNT*MAX_ZC-1:0]  shifted_msg_block,
  output logic                                   shifted_valid,
  output logic [4:0]                             current_col,
  output logic                                   cols_done
);

  localparam int unsigned ROWS = MUL_SH_BLOCKS_COUNT;
  localparam int unsigned ZW   = $clog2(MAX_ZC + 1);
  localparam int unsigned CW   = (SHIFT_W > ZW) ? SHIFT_W : ZW;
  localparam int unsigned COLW = 5;
  localparam int unsigned DW   = ROWS * MAX_ZC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              load;
  logic              zero_start;
  logic              final_beat;
  logic              ready_d;
  logic [SHIFT_W-1:0] zc_q;
  logic [COLW-1:0]   max_q;
  logic [COLW-1:0]   acc_cnt;
  logic [ZW-1:0]     z_eff;
  logic [DW-1:0]     rot_c;

  // Rotate the low z bits of din down by (sh mod z); bits at and above z are cleared.
  function automatic logic [MAX_ZC-1:0] rotate(
    input logic [MAX_ZC-1:0]  din,
    input logic [SHIFT_W-1:0] sh,
    input logic [ZW-1:0]      z
  );
    logic [MAX_ZC-1:0] mask;
    logic [MAX_ZC-1:0] m;
    logic [MAX_ZC-1:0] res;
    logic [ZW-1:0]     s;
    s    = ZW'(CW'(sh) % CW'(z));
    mask = ~({MAX_ZC{1'b1}} << z);
    m    = din & mask;
    res  = (m >> s) | (m << (z - s));
    return res & mask;
  endfunction

  // Effective lifting size: 0 (or anything beyond MAX_ZC) selects MAX_ZC.
  always_comb begin
    z_eff = ZW'(MAX_ZC);
    if (CW'(zc_q) != '0 && CW'(zc_q) <= CW'(MAX_ZC)) begin
      z_eff = ZW'(zc_q);
    end
  end

  always_comb begin
    rot_c = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_mask[r]) begin
        rot_c[r*MAX_ZC +: MAX_ZC] = rotate(msg_block, shift_val[r*SHIFT_W +: SHIFT_W], z_eff);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && max_col_count != '0) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (accept && ({1'b0, acc_cnt} + 6'd1 == {1'b0, max_q})) begin
          next_state = LAST;
        end
      end
      LAST: begin
        if (final_beat) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load       = 1'b0;
    zero_start = 1'b0;
    accept     = 1'b0;
    ready_d    = (next_state == RUN);
    final_beat = shifted_valid && ({1'b0, current_col} + 6'd1 == {1'b0, max_q});
    case (state)
      IDLE: begin
        load       = start;
        zero_start = start && (max_col_count == '0);
      end
      RUN:     accept = msg_valid && msg_ready;
      default: ;
    endcase
  end

  // Sweep bookkeeping: latched config, accept count, output beat count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_ready   <= 1'b0;
      cols_done   <= 1'b0;
      zc_q        <= '0;
      max_q       <= '0;
      acc_cnt     <= '0;
      current_col <= '0;
    end else begin
      msg_ready <= ready_d;
      cols_done <= zero_start | final_beat;
      if (load) begin
        zc_q    <= zc;
        max_q   <= max_col_count;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + COLW'(1);
      end
      if (load) begin
        current_col <= '0;
      end else if (shifted_valid && current_col < max_q) begin
        current_col <= current_col + COLW'(1);
      end
    end
  end

`ifdef LDPC_SHIFT_PIPE_EN
  logic [DW-1:0] pipe_q;
  logic          pipe_v;

  // Two register stages between rotator and output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q            <= '0;
      pipe_v            <= 1'b0;
      shifted_msg_block <= '0;
      shifted_valid     <= 1'b0;
    end else begin
      pipe_v        <= accept;
      shifted_valid <= pipe_v;
      if (accept) begin
        pipe_q <= rot_c;
      end
      if (pipe_v) begin
        shifted_msg_block <= pipe_q;
      end
    end
  end
`else
  // Single output register; holds its value between beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifted_msg_block <= '0;
      shifted_valid     <= 1'b0;
    end else begin
      shifted_valid <= accept;
      if (accept) begin
        shifted_msg_block <= rot_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_msg_block_cyclic_shifter.sv
// Scoreboard bench for msg_block_cyclic_shifter: randomized beats checked against a bit-level rotation model.
module tb_msg_block_cyclic_shifter;

  localparam int unsigned MAX_ZC  = 384;
  localparam int unsigned ROWS    = 46;
  localparam int unsigned SHIFT_W = 9;
  localparam int unsigned DW      = ROWS * MAX_ZC;
  localparam int unsigned SW      = ROWS * SHIFT_W;
`ifdef LDPC_SHIFT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic [SHIFT_W-1:0] zc;
  logic [4:0]         max_col_count;
  logic               msg_valid;
  logic               msg_ready;
  logic [MAX_ZC-1:0]  msg_block;
  logic [SW-1:0]      shift_val;
  logic [ROWS-1:0]    row_mask;
  logic [DW-1:0]      shifted_msg_block;
  logic               shifted_valid;
  logic [4:0]         current_col;
  logic               cols_done;

  typedef struct {
    logic [DW-1:0] data;
    int            exp_cyc;
    int            col;
    bit            last;
    int            maxc;
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int done_due = -10;
  int done_col = 0;
  int cur_zc = 0;
  int cur_max = 0;
  int beat_idx = 0;

  msg_block_cyclic_shifter #(
    .MAX_ZC(MAX_ZC), .MUL_SH_BLOCKS_COUNT(ROWS), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .zc(zc), .max_col_count(max_col_count),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_block(msg_block),
    .shift_val(shift_val), .row_mask(row_mask), .shifted_msg_block(shifted_msg_block),
    .shifted_valid(shifted_valid), .current_col(current_col), .cols_done(cols_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: out[r][j] = msg[(j + shift mod Z) mod Z] for j < Z on unmasked rows
  function automatic logic [DW-1:0] model(input logic [MAX_ZC-1:0] m, input logic [SW-1:0] sh,
                                          input logic [ROWS-1:0] k, input int zcv);
    int z;
    int s;
    logic [DW-1:0] o;
    z = (zcv == 0 || zcv > int'(MAX_ZC)) ? int'(MAX_ZC) : zcv;
    o = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (k[r]) begin
        s = int'(sh[r*SHIFT_W +: SHIFT_W]) % z;
        for (int j = 0; j < z; j++) o[r*MAX_ZC + j] = m[(j + s) % z];
      end
    end
    return o;
  endfunction

  function automatic logic [MAX_ZC-1:0] rmsg();
    logic [MAX_ZC-1:0] v;
    for (int i = 0; i < int'(MAX_ZC) / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] rsh();
    logic [SW-1:0] v;
    for (int r = 0; r < int'(ROWS); r++) v[r*SHIFT_W +: SHIFT_W] = 9'($urandom_range(0, 511));
    return v;
  endfunction

  function automatic logic [ROWS-1:0] rmask();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[ROWS-1:0];
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_data(input logic [DW-1:0] a, input logic [DW-1:0] e, input string name);
    int fr;
    nchk++;
    if (a !== e) begin
      nerr++;
      fr = 0;
      for (int r = int'(ROWS) - 1; r >= 0; r--) if (a[r*MAX_ZC +: MAX_ZC] !== e[r*MAX_ZC +: MAX_ZC]) fr = r;
      $display("FAIL %s row %0d: got %h expected %h", name, fr, a[fr*MAX_ZC +: MAX_ZC], e[fr*MAX_ZC +: MAX_ZC]);
    end
  endtask

  // Monitor: pop one expectation per shifted_valid; track the cols_done pulse
  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    if (!reset) begin
      exp_done = (cyc == done_due);
      if (cols_done || exp_done) begin
        chk(cols_done == exp_done, "cols_done", int'(cols_done), int'(exp_done));
        if (exp_done) chk(int'(current_col) == done_col, "current_col_at_done", int'(current_col), done_col);
      end
      if (shifted_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_shifted_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk_data(shifted_msg_block, e.data, "shifted_msg_block");
          chk(cyc == e.exp_cyc, "latency_cycle", cyc, e.exp_cyc);
          chk(int'(current_col) == e.col, "current_col_in_beat", int'(current_col), e.col);
          if (e.last) begin
            done_due = cyc + 1;
            done_col = e.maxc;
          end
        end
      end
    end
  end

  task automatic do_start(input int zcv, input int maxc);
    @(negedge clk);
    start = 1'b1;
    zc = SHIFT_W'(zcv);
    max_col_count = 5'(maxc);
    cur_zc = zcv;
    cur_max = maxc;
    beat_idx = 0;
    if (maxc == 0) begin
      done_due = cyc + 1;
      done_col = 0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [MAX_ZC-1:0] m, input logic [SW-1:0] s, input logic [ROWS-1:0] k);
    exp_t e;
    int n;
    @(negedge clk);
    msg_block = m;
    shift_val = s;
    row_mask = k;
    msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(msg_ready, "msg_ready_wait", int'(msg_ready), 1);
    if (!msg_ready) begin
      msg_valid = 1'b0;
      return;
    end
    e.data = model(m, s, k, cur_zc);
    e.exp_cyc = cyc + LAT;
    e.col = beat_idx;
    e.last = (beat_idx == cur_max - 1);
    e.maxc = cur_max;
    sb.push_back(e);
    beat_idx++;
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_block = rmsg();
    shift_val = rsh();
    row_mask = rmask();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_sweep(input int zcv, input int maxc, input int gap);
    do_start(zcv, maxc);
    for (int b = 0; b < maxc; b++) begin
      send_beat(rmsg(), rsh(), rmask());
      repeat (gap) @(negedge clk);
    end
    drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(msg_ready == 1'b0, {tag, "_msg_ready"}, int'(msg_ready), 0);
    chk(shifted_valid == 1'b0, {tag, "_shifted_valid"}, int'(shifted_valid), 0);
    chk(cols_done == 1'b0, {tag, "_cols_done"}, int'(cols_done), 0);
    chk(current_col == 5'd0, {tag, "_current_col"}, int'(current_col), 0);
    chk_data(shifted_msg_block, '0, {tag, "_shifted_msg_block"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [MAX_ZC-1:0] m;
    logic [MAX_ZC-1:0] row0;
    logic [SW-1:0]     s;
    reset = 1'b1;
    start = 1'b0;
    zc = '0;
    max_col_count = '0;
    msg_valid = 1'b0;
    msg_block = '0;
    shift_val = '0;
    row_mask = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // zc=8, one column, shift 3 on row 0 only
    do_start(8, 1);
    m = '0;
    m[0] = 1'b1;
    s = rsh();
    s[SHIFT_W-1:0] = 9'd3;
    send_beat(m, s, 46'd1);
    drain();
    row0 = shifted_msg_block[MAX_ZC-1:0];
    chk(row0 == 384'h20, "s1_row0_is_0x20", int'(row0[31:0]), 32);
    chk(current_col == 5'd1, "s1_current_col", int'(current_col), 1);

    // zc=0 selects 384; shift 383 moves bit0 to bit1
    do_start(0, 1);
    s = '0;
    for (int r = 0; r < int'(ROWS); r++) s[r*SHIFT_W +: SHIFT_W] = 9'd383;
    send_beat(m, s, rmask() | 46'd1);
    drain();
    row0 = shifted_msg_block[MAX_ZC-1:0];
    chk(row0 == 384'h2, "s2_row0_is_bit1", int'(row0[31:0]), 2);

    // zc=10 with shift 13 behaves as shift 3; masked rows zero
    do_start(10, 2);
    for (int r = 0; r < int'(ROWS); r++) s[r*SHIFT_W +: SHIFT_W] = 9'd13;
    send_beat(rmsg(), s, rmask());
    send_beat(rmsg(), s, rmask());
    drain();

    // 22 columns, valid every other cycle, with a start issued mid-sweep that must be ignored
    do_start(int'($urandom_range(1, 384)), 22);
    for (int b = 0; b < 22; b++) begin
      send_beat(rmsg(), rsh(), rmask());
      if (b == 3) begin
        start = 1'b1;
        zc = 9'd5;
        max_col_count = 5'd3;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      if (b == 21) chk(msg_ready == 1'b0, "s4_ready_drops", int'(msg_ready), 0);
    end
    drain();

    // max_col_count=0: only a cols_done pulse, no ready, no output
    do_start(20, 0);
    for (int i = 0; i < 3; i++) begin
      chk(msg_ready == 1'b0, "s5_ready_low", int'(msg_ready), 0);
      @(negedge clk);
    end

    // reset after 5 of 10 beats, then a clean full sweep
    do_start(37, 10);
    for (int b = 0; b < 5; b++) send_beat(rmsg(), rsh(), rmask() | 46'd1);
    drain();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    done_due = -10;
    @(negedge clk);
    reset = 1'b0;
    run_sweep(37, 10, 0);

    // random sweeps
    for (int t = 0; t < 4; t++) begin
      run_sweep(int'($urandom_range(0, 384)), int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));
    end

    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/msg_block_cyclic_shifter.md
MSG_BLOCK_CYCLIC_SHIFTER -- requirements
Module: msg_block_cyclic_shifter

Interface
REQ-001 SHALL take parameter MAX_ZC, default 384, the maximum lifting size in bits.
REQ-002 SHALL take parameter MUL_SH_BLOCKS_COUNT, default 46, the number of base-graph rows shifted in parallel.
REQ-003 SHALL take parameter SHIFT_W, default 9, the width of the shift and zc fields.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a column sweep; samples zc and max_col_count.
- zc  in  SHIFT_W  lifting size; 0 means MAX_ZC.
- max_col_count  in  5  message columns in the sweep.
- msg_valid  in  1  msg_block valid.
- msg_ready  out  1  block accepts msg_block.
- msg_block  in  MAX_ZC  one Zc message column; bits >= zc ignored.
- shift_val  in  MUL_SH_BLOCKS_COUNT x SHIFT_W  per-row shift for the column being accepted.
- row_mask  in  MUL_SH_BLOCKS_COUNT  1 = non-null base-graph entry for that row.
- shifted_msg_block  out  MUL_SH_BLOCKS_COUNT x MAX_ZC  rotated column per row; feeds the parity accumulator.
- shifted_valid  out  1  shifted_msg_block valid; drives the accumulator evaluate enable.
- current_col  out  5  output beats produced in this sweep.
- cols_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-005 SHALL implement FSM states IDLE, RUN and LAST; reset state is IDLE.
REQ-006 In IDLE, start=1 SHALL latch zc and max_col_count, clear current_col to 0, and go to RUN; if max_col_count=0, it SHALL instead pulse cols_done on the next cycle and stay in IDLE.
REQ-007 msg_ready SHALL be 1 only in RUN; a beat is accepted when msg_valid and msg_ready are both 1.
REQ-008 In RUN, the accept of beat number max_col_count SHALL move the FSM to LAST; LAST SHALL return to IDLE after the final output beat is emitted.
REQ-009 start while in RUN or LAST SHALL be ignored.
REQ-010 For each row r with row_mask[r]=1: shifted_msg_block[r][j] = msg_block[(j + s) mod Z] for j < Z, where Z is the effective zc and s = shift_val[r] mod Z.
REQ-011 Bits j >= Z, and every row with row_mask[r]=0, SHALL output all zeros.
REQ-012 shift_val and row_mask SHALL be sampled together with msg_block on accept.
REQ-013 Latency from accept to shifted_valid SHALL be 1 cycle (see REQ-019).
REQ-014 shifted_valid SHALL be high exactly one cycle per accepted beat.
REQ-015 current_col SHALL increment by 1 at the end of each shifted_valid cycle and SHALL saturate at max_col_count.
REQ-016 cols_done SHALL pulse for 1 cycle, in the cycle after the last shifted_valid, when current_col equals max_col_count.
REQ-017 shifted_msg_block SHALL hold its value when shifted_valid=0.

Reset
REQ-018 Asserting reset at any time, including mid-sweep, SHALL asynchronously force: state IDLE, msg_ready=0, shifted_valid=0, cols_done=0, current_col=0, all shifted_msg_block rows=0, and latched zc and max_col_count=0.

Configuration
REQ-019 Macro LDPC_SHIFT_PIPE_EN:
- Defined: adds a second register stage after the rotator; latency becomes 2 cycles; shifted_valid, current_col and cols_done shift by one cycle; accept rules are unchanged.
- Undefined: latency is 1 cycle as in REQ-013.

Verification
REQ-020 Bench SHALL cover the following directed scenarios:
- zc=8, max_col_count=1, msg_block=0x01, shift_val[0]=3, row_mask=1 -> row0 = 0x20 one cycle after accept; cols_done pulses the following cycle; current_col=1.
- zc=0 (MAX_ZC=384), shift_val=383, msg_block bit0=1 -> output bit1 set; all other bits 0.
- zc=10, shift_val=13 -> output identical to shift 3; bits 10..383 zero; masked rows zero.
- max_col_count=22 with msg_valid toggled every other cycle -> exactly 22 shifted_valid pulses; current_col steps 0..22; msg_ready drops after the 22nd accept.
- max_col_count=0 with start -> no shifted_valid; cols_done pulses next cycle; msg_ready stays 0.
- reset asserted after 5 of 10 beats -> all outputs 0 immediately; a new start runs a full 10-beat sweep correctly; repeat with LDPC_SHIFT_PIPE_EN defined and check latency 2.
